// File: rtl/bip_datapath.sv
// Accumulator datapath of the BIP CPU: accumulator with registered status flags,
// add/subtract ALU, immediate sign extension, data RAM interface and a profiling cycle counter.
module bip_datapath #(
    parameter int DBITS  = 16,
    parameter int OPBITS = 11
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        sel_A,
    input  logic              sel_B,
    input  logic              w_acc,
    input  logic              o_op,
    input  logic              h_flg,
    input  logic [OPBITS-1:0] operand,
    input  logic [DBITS-1:0]  ram_rdata,
    output logic [OPBITS-1:0] ram_addr,
    output logic [DBITS-1:0]  ram_wdata,
    output logic [DBITS-1:0]  acc,
    output logic              zero,
    output logic              neg,
    output logic              ovf,
    output logic [31:0]       cycles
);

    localparam logic [1:0] SEL_RAM  = 2'd0;
    localparam logic [1:0] SEL_IMM  = 2'd1;
    localparam logic [1:0] SEL_ALU  = 2'd2;
    localparam logic [1:0] SEL_HOLD = 2'd3;

    localparam logic [31:0] CYCLES_MAX = 32'hFFFF_FFFF;

    logic [DBITS-1:0] acc_q;
    logic             zero_q;
    logic             neg_q;
    logic             ovf_q;
    logic [31:0]      cycles_q;

    logic [DBITS-1:0] imm;
    logic [DBITS-1:0] b_val;
    logic [DBITS-1:0] res;
    logic             ovf_det;
    logic [DBITS-1:0] next_acc;
    logic             wr_en;

    assign imm   = {{(DBITS-OPBITS){operand[OPBITS-1]}}, operand};
    assign b_val = sel_B ? imm : ram_rdata;

    // Overflow is judged on sign bits only; the carry out of the MSB is discarded.
    always_comb begin
        res     = '0;
        ovf_det = 1'b0;
        if (o_op) begin
            res     = acc_q - b_val;
            ovf_det = (acc_q[DBITS-1] != b_val[DBITS-1]) && (res[DBITS-1] != acc_q[DBITS-1]);
        end else begin
            res     = acc_q + b_val;
            ovf_det = (acc_q[DBITS-1] == b_val[DBITS-1]) && (res[DBITS-1] != acc_q[DBITS-1]);
        end
    end

    always_comb begin
        next_acc = acc_q;
        case (sel_A)
            SEL_RAM:  next_acc = ram_rdata;
            SEL_IMM:  next_acc = imm;
            SEL_ALU:  next_acc = res;
            SEL_HOLD: next_acc = acc_q;
            default:  next_acc = acc_q;
        endcase
    end

    // Halt blocks every architectural write, whatever the decoder asks for.
    assign wr_en = w_acc & ~h_flg;

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q    <= '0;
            zero_q   <= 1'b1;
            neg_q    <= 1'b0;
            ovf_q    <= 1'b0;
            cycles_q <= '0;
        end else begin
            if (wr_en) begin
                acc_q  <= next_acc;
                zero_q <= (next_acc == '0);
                neg_q  <= next_acc[DBITS-1];
                if ((sel_A == SEL_ALU) && ovf_det) begin
                    ovf_q <= 1'b1;
                end
            end
            if (!h_flg && (cycles_q != CYCLES_MAX)) begin
                cycles_q <= cycles_q + 32'd1;
            end
        end
    end

    assign ram_addr  = operand;
    assign ram_wdata = acc_q;
    assign acc       = acc_q;
    assign zero      = zero_q;
    assign neg       = neg_q;
    assign ovf       = ovf_q;
    assign cycles    = cycles_q;

endmodule

// File: tb/tb_bip_datapath.sv
// Directed self-checking bench for bip_datapath: hand-computed accumulator, flag,
// RAM interface and cycle-counter expectations.
module tb_bip_datapath;

    localparam int DBITS  = 16;
    localparam int OPBITS = 11;

    logic              clk;
    logic              reset;
    logic [1:0]        sel_A;
    logic              sel_B;
    logic              w_acc;
    logic              o_op;
    logic              h_flg;
    logic [OPBITS-1:0] operand;
    logic [DBITS-1:0]  ram_rdata;
    logic [OPBITS-1:0] ram_addr;
    logic [DBITS-1:0]  ram_wdata;
    logic [DBITS-1:0]  acc;
    logic              zero;
    logic              neg;
    logic              ovf;
    logic [31:0]       cycles;

    int n_checks;
    int n_fail;

    logic [DBITS-1:0] exp_q[$];
    logic [31:0]      exp_cycles;

    bip_datapath #(.DBITS(DBITS), .OPBITS(OPBITS)) dut (
        .clk       (clk),
        .reset     (reset),
        .sel_A     (sel_A),
        .sel_B     (sel_B),
        .w_acc     (w_acc),
        .o_op      (o_op),
        .h_flg     (h_flg),
        .operand   (operand),
        .ram_rdata (ram_rdata),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .acc       (acc),
        .zero      (zero),
        .neg       (neg),
        .ovf       (ovf),
        .cycles    (cycles)
    );

    // Clock and reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One rising edge; inputs are driven and outputs sampled on the falling edge.
    // The bench keeps its own model of the cycle counter.
    task automatic step();
        @(posedge clk);
        if (reset)
            exp_cycles = 32'd0;
        else if (!h_flg && exp_cycles != 32'hFFFF_FFFF)
            exp_cycles = exp_cycles + 32'd1;
        @(negedge clk);
    endtask

    task automatic drive(input logic [1:0] a, input logic b, input logic w, input logic op,
                         input logic h, input logic [OPBITS-1:0] opnd, input logic [DBITS-1:0] rd);
        sel_A     = a;
        sel_B     = b;
        w_acc     = w;
        o_op      = op;
        h_flg     = h;
        operand   = opnd;
        ram_rdata = rd;
    endtask

    // Drive a control word, clock it, and score acc against the queued expectation.
    task automatic exec(input string tag, input logic [1:0] a, input logic b, input logic w,
                        input logic op, input logic h, input logic [OPBITS-1:0] opnd,
                        input logic [DBITS-1:0] rd, input logic [DBITS-1:0] exp_acc);
        drive(a, b, w, op, h, opnd, rd);
        exp_q.push_back(exp_acc);
        step();
        check_eq({tag, ".acc"}, 32'(acc), 32'(exp_q.pop_front()));
        check_eq({tag, ".cycles"}, cycles, exp_cycles);
    endtask

    task automatic check_flags(input string tag, input logic z, input logic n, input logic o);
        check_eq({tag, ".zero"}, 32'(zero), 32'(z));
        check_eq({tag, ".neg"}, 32'(neg), 32'(n));
        check_eq({tag, ".ovf"}, 32'(ovf), 32'(o));
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        exp_cycles = 32'd0;
        reset      = 1'b1;
        drive(2'd0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        step();
        step();
        check_eq("reset.acc", 32'(acc), 32'h0);
        check_eq("reset.cycles", cycles, 32'h0);
        check_flags("reset", 1'b1, 1'b0, 1'b0);
        reset = 1'b0;

        // Immediate loads with sign extension
        exec("imm_7ff", 2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 11'h7FF, 16'h0000, 16'hFFFF);
        check_flags("imm_7ff", 1'b0, 1'b1, 1'b0);
        check_eq("imm_7ff.wdata", 32'(ram_wdata), 32'hFFFF);
        exec("imm_3ff", 2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 11'h3FF, 16'h0000, 16'h03FF);
        check_flags("imm_3ff", 1'b0, 1'b0, 1'b0);

        // 5 - 5 = 0
        exec("ld5", 2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 11'd5, 16'h0000, 16'h0005);
        exec("sub5", 2'd2, 1'b1, 1'b1, 1'b1, 1'b0, 11'd5, 16'h0000, 16'h0000);
        check_flags("sub5", 1'b1, 1'b0, 1'b0);

        // RAM load; address is combinational from operand
        drive(2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 11'h123, 16'h1234);
        #1;
        check_eq("ram_addr.123", 32'(ram_addr), 32'h123);
        operand = 11'h456;
        #1;
        check_eq("ram_addr.456", 32'(ram_addr), 32'h456);
        exec("ld_ram", 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 11'h456, 16'h1234, 16'h1234);
        check_eq("ld_ram.wdata", 32'(ram_wdata), 32'h1234);

        // 7FFF + 1 overflows; 8000 - 1 overflows too; ovf stays sticky
        exec("ld_7fff", 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 11'h0, 16'h7FFF, 16'h7FFF);
        exec("add_ovf", 2'd2, 1'b0, 1'b1, 1'b0, 1'b0, 11'h0, 16'h0001, 16'h8000);
        check_flags("add_ovf", 1'b0, 1'b1, 1'b1);
        exec("sub_ovf", 2'd2, 1'b0, 1'b1, 1'b1, 1'b0, 11'h0, 16'h0001, 16'h7FFF);
        check_flags("sub_ovf", 1'b0, 1'b0, 1'b1);
        exec("sticky", 2'd2, 1'b1, 1'b1, 1'b0, 1'b0, 11'd1, 16'h0000, 16'h8000);
        check_flags("sticky", 1'b0, 1'b1, 1'b1);

        // Clear with reset, then carry-only add (1 + FFFF) must not flag overflow
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_flags("reset2", 1'b1, 1'b0, 1'b0);
        exec("ld1", 2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 11'd1, 16'h0000, 16'h0001);
        exec("carry", 2'd2, 1'b0, 1'b1, 1'b0, 1'b0, 11'h0, 16'hFFFF, 16'h0000);
        check_flags("carry", 1'b1, 1'b0, 1'b0);

        // ALU would overflow but sel_A picks RAM: ovf must stay clear
        exec("ld_7fff2", 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 11'h0, 16'h7FFF, 16'h7FFF);
        exec("ovf_ign", 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 11'h0, 16'h0001, 16'h0001);
        check_flags("ovf_ign", 1'b0, 1'b0, 1'b0);
        exec("hold", 2'd3, 1'b0, 1'b1, 1'b0, 1'b0, 11'h0, 16'hAAAA, 16'h0001);
        check_flags("hold", 1'b0, 1'b0, 1'b0);
        exec("no_wr", 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 11'd9, 16'h0000, 16'h0001);

        // Halt blocks writes and freezes the counter
        for (int i = 0; i < 3; i++) begin
            exec("halt", 2'd1, 1'b0, 1'b1, 1'b0, 1'b1, 11'd9, 16'h0000, 16'h0001);
            check_flags("halt", 1'b0, 1'b0, 1'b0);
        end
        exec("resume", 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 11'd9, 16'h0000, 16'h0001);
        exec("resume2", 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 11'd9, 16'h0000, 16'h0001);

        // Counter saturation
        force dut.cycles_q = 32'hFFFF_FFFE;
        #1;
        release dut.cycles_q;
        exp_cycles = 32'hFFFF_FFFE;
        for (int i = 0; i < 3; i++) begin
            exec("sat", 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 11'h0, 16'h0000, 16'h0001);
        end

        // Set ovf, then reset mid-run while a write is requested
        exec("ld_7fff3", 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 11'h0, 16'h7FFF, 16'h7FFF);
        exec("add_ovf2", 2'd2, 1'b0, 1'b1, 1'b0, 1'b0, 11'h0, 16'h0001, 16'h8000);
        check_flags("add_ovf2", 1'b0, 1'b1, 1'b1);
        reset = 1'b1;
        exec("mid_reset", 2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 11'h7FF, 16'h0000, 16'h0000);
        check_flags("mid_reset", 1'b1, 1'b0, 1'b0);
        check_eq("mid_reset.cyc0", cycles, 32'h0);
        reset = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
